// File: rtl/stage5_field_extract.sv
// ---------------------------------------------------------------------------
// stage5_field_extract
//   N-channel field extractor for stage-5 message decode. Each channel takes a
//   decoded message over valid/ready and slices message[FIELD_MSB:FIELD_LSB]
//   when message_en is set and its mux control equals MATCH_CODE. Otherwise it
//   substitutes DEFAULT_VALUE. Results go out through a 2-entry skid buffer.
//   Each channel also keeps a saturating count of accepted hits.
//
// Ports (channel c occupies slice c of every flattened bus)
//   clk, rst      : rising-edge clock, async active-high reset
//   message_en    : global extraction enable, sampled at accept
//   msg_valid/rdy : per-channel input handshake
//   message       : CHANNELS*MSG_BITS decoded messages
//   mux_control   : CHANNELS*CTRL_BITS message type codes
//   field_valid/ready, field_data, field_hit : per-channel output handshake
//   count_clear   : synchronous clear of all hit counters
//   hit_count     : CHANNELS*CNT_BITS saturating hit counts
// ---------------------------------------------------------------------------

// One channel: extract, 2-entry skid buffer, hit counter.
module stage5_fx_lane #(
  parameter int                           MSG_BITS      = 512,
  parameter int                           CTRL_BITS     = 4,
  parameter int                           FIELD_MSB     = 95,
  parameter int                           FIELD_LSB     = 64,
  parameter logic [CTRL_BITS-1:0]         MATCH_CODE    = 4'h1,
  parameter logic [FIELD_MSB-FIELD_LSB:0] DEFAULT_VALUE = '0,
  parameter int                           CNT_BITS      = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           message_en,
  input  logic                           msg_valid,
  output logic                           msg_ready,
  input  logic [MSG_BITS-1:0]            message,
  input  logic [CTRL_BITS-1:0]           mux_control,
  output logic                           field_valid,
  input  logic                           field_ready,
  output logic [FIELD_MSB-FIELD_LSB:0]   field_data,
  output logic                           field_hit,
  input  logic                           count_clear,
  output logic [CNT_BITS-1:0]            hit_count
);
  localparam int FW = FIELD_MSB - FIELD_LSB + 1;

  typedef struct packed {
    logic [FW-1:0] data;
    logic          hit;
  } entry_t;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

  state_t              r_state;
  entry_t              r_out;
  entry_t              r_skid;
  logic                r_valid;
  logic                r_ready;
  logic [CNT_BITS-1:0] r_cnt;

  logic   w_accept;
  logic   w_pop;
  logic   w_hit;
  entry_t w_new;
  logic   w_unused;

  assign w_hit    = message_en & (mux_control == MATCH_CODE);
  assign w_new    = '{data: (w_hit ? message[FIELD_MSB:FIELD_LSB] : DEFAULT_VALUE),
                      hit:  w_hit};
  assign w_accept = msg_valid & r_ready;
  assign w_pop    = r_valid & field_ready;
  // Message bits outside the field are intentionally ignored.
  assign w_unused = ^message;

  // r_ready comes out of reset low and rises on the first edge after
  // release; afterwards it depends only on state (low only in FULL).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_EMPTY;
      r_valid <= 1'b0;
      r_ready <= 1'b0;
      r_out   <= '{data: DEFAULT_VALUE, hit: 1'b0};
      r_skid  <= '{data: DEFAULT_VALUE, hit: 1'b0};
    end else begin
      case (r_state)
        S_EMPTY: begin
          r_ready <= 1'b1;
          if (w_accept) begin
            r_out   <= w_new;
            r_valid <= 1'b1;
            r_state <= S_ONE;
          end
        end
        S_ONE: begin
          if (w_accept && !w_pop) begin
            r_skid  <= w_new;
            r_ready <= 1'b0;
            r_state <= S_FULL;
          end else if (w_accept && w_pop) begin
            r_out <= w_new;
          end else if (w_pop) begin
            r_valid <= 1'b0;
            r_state <= S_EMPTY;
          end
        end
        S_FULL: begin
          // msg_ready is low here, so only a pop can happen.
          if (w_pop) begin
            r_out   <= r_skid;
            r_ready <= 1'b1;
            r_state <= S_ONE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_EMPTY;
        end
      endcase
    end
  end

  // Clear has priority over a simultaneous hit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (count_clear) begin
      r_cnt <= '0;
    end else if (w_accept && w_hit && (r_cnt != {CNT_BITS{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign msg_ready   = r_ready;
  assign field_valid = r_valid;
  assign field_data  = r_out.data;
  assign field_hit   = r_out.hit;
  assign hit_count   = r_cnt;
endmodule

module stage5_field_extract #(
  parameter int                           CHANNELS      = 3,
  parameter int                           MSG_BITS      = 512,
  parameter int                           CTRL_BITS     = 4,
  parameter int                           FIELD_MSB     = 95,
  parameter int                           FIELD_LSB     = 64,
  parameter logic [CTRL_BITS-1:0]         MATCH_CODE    = 4'h1,
  parameter logic [FIELD_MSB-FIELD_LSB:0] DEFAULT_VALUE = '0,
  parameter int                           CNT_BITS      = 16
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        message_en,
  input  logic [CHANNELS-1:0]                         msg_valid,
  output logic [CHANNELS-1:0]                         msg_ready,
  input  logic [CHANNELS*MSG_BITS-1:0]                message,
  input  logic [CHANNELS*CTRL_BITS-1:0]               mux_control,
  output logic [CHANNELS-1:0]                         field_valid,
  input  logic [CHANNELS-1:0]                         field_ready,
  output logic [CHANNELS*(FIELD_MSB-FIELD_LSB+1)-1:0] field_data,
  output logic [CHANNELS-1:0]                         field_hit,
  input  logic                                        count_clear,
  output logic [CHANNELS*CNT_BITS-1:0]                hit_count
);
  localparam int FW = FIELD_MSB - FIELD_LSB + 1;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    stage5_fx_lane #(
      .MSG_BITS      (MSG_BITS),
      .CTRL_BITS     (CTRL_BITS),
      .FIELD_MSB     (FIELD_MSB),
      .FIELD_LSB     (FIELD_LSB),
      .MATCH_CODE    (MATCH_CODE),
      .DEFAULT_VALUE (DEFAULT_VALUE),
      .CNT_BITS      (CNT_BITS)
    ) u_lane (
      .clk         (clk),
      .rst         (rst),
      .message_en  (message_en),
      .msg_valid   (msg_valid[c]),
      .msg_ready   (msg_ready[c]),
      .message     (message[c*MSG_BITS +: MSG_BITS]),
      .mux_control (mux_control[c*CTRL_BITS +: CTRL_BITS]),
      .field_valid (field_valid[c]),
      .field_ready (field_ready[c]),
      .field_data  (field_data[c*FW +: FW]),
      .field_hit   (field_hit[c]),
      .count_clear (count_clear),
      .hit_count   (hit_count[c*CNT_BITS +: CNT_BITS])
    );
  end
endmodule

// File: tb/tb_stage5_field_extract.sv
module tb_stage5_field_extract;
  localparam int CH = 3, MB = 512, CB = 4, FW = 32, NB = 2;
  localparam int CMAX = (1 << NB) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              message_en = 1'b0;
  logic              count_clear = 1'b0;
  logic [CH-1:0]     msg_valid = '0;
  logic [CH-1:0]     field_ready = '0;
  logic [CH*MB-1:0]  message = '0;
  logic [CH*CB-1:0]  mux_control = '0;
  wire  [CH-1:0]     msg_ready, field_valid, field_hit;
  wire  [CH*FW-1:0]  field_data;
  wire  [CH*NB-1:0]  hit_count;

  stage5_field_extract #(.CNT_BITS(NB)) dut (
    .clk(clk), .rst(rst), .message_en(message_en),
    .msg_valid(msg_valid), .msg_ready(msg_ready),
    .message(message), .mux_control(mux_control),
    .field_valid(field_valid), .field_ready(field_ready),
    .field_data(field_data), .field_hit(field_hit),
    .count_clear(count_clear), .hit_count(hit_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [FW-1:0] d;
    logic          h;
  } exp_t;

  exp_t sbq[CH][$];
  int   cnt_m[CH];
  int   nvec = 0, nerr = 0;
  bit   chk_en = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every pop is checked against the channel scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      for (int c = 0; c < CH; c++) begin
        if (field_valid[c] && field_ready[c]) begin
          if (sbq[c].size() == 0) begin
            nvec++; nerr++;
            $display("FAIL pop_ch%0d: got %0h with nothing expected", c, field_data[c*FW +: FW]);
          end else begin
            exp_t e;
            e = sbq[c].pop_front();
            chk($sformatf("data_ch%0d", c), 64'(field_data[c*FW +: FW]), 64'(e.d));
            chk($sformatf("hit_ch%0d", c), 64'(field_hit[c]), 64'(e.h));
          end
        end
      end
    end
  end

  // Counter model: compare what the last edge produced, then predict the next edge.
  always @(negedge clk) begin
    if (!rst && chk_en) begin
      for (int c = 0; c < CH; c++) begin
        chk($sformatf("cnt_ch%0d", c), 64'(hit_count[c*NB +: NB]), 64'(cnt_m[c]));
        if (count_clear) cnt_m[c] = 0;
        else if (msg_valid[c] && msg_ready[c] && message_en &&
                 mux_control[c*CB +: CB] == 4'h1 && cnt_m[c] < CMAX)
          cnt_m[c] = cnt_m[c] + 1;
      end
    end
  end

  task automatic rand_msg(int c);
    for (int w = 0; w < MB/32; w++) message[c*MB + w*32 +: 32] = $urandom;
  endtask

  // Drive one message at posedge+1, wait (bounded) for ready, push the
  // hand-computed expectation, release after the accept edge.
  task automatic send(int c, logic [31:0] fld, logic [3:0] ctrl, logic en,
                      logic [31:0] ed, logic eh);
    int n = 0;
    rand_msg(c);
    message[c*MB + 64 +: 32] = fld;
    mux_control[c*CB +: CB] = ctrl;
    message_en = en;
    msg_valid[c] = 1'b1;
    @(negedge clk);
    while (!msg_ready[c] && n < 50) begin n++; @(negedge clk); end
    if (!msg_ready[c]) begin
      nvec++; nerr++;
      $display("FAIL send_timeout_ch%0d: msg_ready %0b required 1", c, msg_ready[c]);
    end else begin
      sbq[c].push_back('{d: ed, h: eh});
    end
    @(posedge clk); #1;
    msg_valid[c] = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] v;
    for (int c = 0; c < CH; c++) cnt_m[c] = 0;

    // Reset state
    #2;
    chk("rst_ready", 64'(msg_ready), 64'(0));
    chk("rst_fvalid", 64'(field_valid), 64'(0));
    chk("rst_fdata", 64'(field_data), 64'(0));
    chk("rst_fhit", 64'(field_hit), 64'(0));
    chk("rst_cnt", 64'(hit_count), 64'(0));
    #10 rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", 64'(msg_ready), 64'(3'b111));
    chk("fvalid_after_rst", 64'(field_valid), 64'(0));
    chk_en = 1;
    field_ready = '1;

    // Basic hit on ch0
    send(0, 32'hDEADBEEF, 4'h1, 1'b1, 32'hDEADBEEF, 1'b1);
    chk("basic_fvalid", 64'(field_valid[0]), 64'(1));
    chk("basic_data", 64'(field_data[31:0]), 64'h0DEADBEEF);
    chk("basic_hit", 64'(field_hit[0]), 64'(1));
    chk("basic_cnt", 64'(hit_count[1:0]), 64'(1));

    // Mismatch and disable on ch1
    send(1, 32'h12345678, 4'h2, 1'b1, 32'h0, 1'b0);
    send(1, 32'hCAFEF00D, 4'h1, 1'b0, 32'h0, 1'b0);
    chk("mismatch_cnt", 64'(hit_count[3:2]), 64'(0));
    message_en = 1'b1;

    // Backpressure on ch2
    field_ready[2] = 1'b0;
    send(2, 32'hAAAA0001, 4'h1, 1'b1, 32'hAAAA0001, 1'b1);
    send(2, 32'hBBBB0002, 4'h1, 1'b1, 32'hBBBB0002, 1'b1);
    chk("bp_ready_full", 64'(msg_ready[2]), 64'(0));
    msg_valid[2] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("bp_c_held", 64'(msg_ready[2]), 64'(0));
    chk("bp_stall_data", 64'(field_data[64 +: 32]), 64'h0AAAA0001);
    field_ready[2] = 1'b1;
    send(2, 32'hCCCC0003, 4'h1, 1'b1, 32'hCCCC0003, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_drained", 64'(sbq[2].size()), 64'(0));

    // Saturation and clear on ch0 (count was 1)
    for (int i = 0; i < 5; i++) begin
      v = $urandom;
      send(0, v, 4'h1, 1'b1, v, 1'b1);
    end
    chk("sat_cnt", 64'(hit_count[1:0]), 64'(3));
    count_clear = 1'b1;
    send(0, 32'h5A5A5A5A, 4'h1, 1'b1, 32'h5A5A5A5A, 1'b1);
    count_clear = 1'b0;
    chk("clear_wins", 64'(hit_count), 64'(0));

    // Async reset while ch2 is FULL
    field_ready[2] = 1'b0;
    send(0, 32'h11111111, 4'h1, 1'b1, 32'h11111111, 1'b1);
    send(2, 32'h22222222, 4'h1, 1'b1, 32'h22222222, 1'b1);
    send(2, 32'h33333333, 4'h1, 1'b1, 32'h33333333, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("arst_fvalid", 64'(field_valid), 64'(0));
    chk("arst_cnt", 64'(hit_count), 64'(0));
    chk("arst_ready", 64'(msg_ready), 64'(0));
    for (int c = 0; c < CH; c++) begin sbq[c].delete(); cnt_m[c] = 0; end
    rst = 1'b0;
    field_ready = '1;
    @(posedge clk); #1;
    chk("arst_ready_after", 64'(msg_ready), 64'(3'b111));

    // Random concurrency on all channels
    for (int cyc = 0; cyc < 10000; cyc++) begin
      message_en  = ($urandom_range(0, 7) != 0);
      count_clear = ($urandom_range(0, 63) == 0);
      for (int c = 0; c < CH; c++) begin
        msg_valid[c]   = $urandom_range(0, 1) == 1;
        field_ready[c] = $urandom_range(0, 3) != 0;
        rand_msg(c);
        mux_control[c*CB +: CB] = 4'($urandom_range(0, 3));
      end
      @(negedge clk);
      for (int c = 0; c < CH; c++) begin
        if (msg_valid[c] && msg_ready[c]) begin
          logic h;
          h = message_en && (mux_control[c*CB +: CB] == 4'h1);
          sbq[c].push_back('{d: (h ? message[c*MB + 64 +: 32] : 32'h0), h: h});
        end
      end
      @(posedge clk); #1;
    end
    msg_valid = '0;
    count_clear = 1'b0;
    field_ready = '1;
    repeat (5) @(posedge clk);
    #1;
    for (int c = 0; c < CH; c++)
      chk($sformatf("final_empty_ch%0d", c), 64'(sbq[c].size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/stage5_field_extract.md
# stage5_field_extract

Parametrised N-channel field extractor for the stage-5 message decode. Each channel accepts decoded messages over a valid/ready handshake and slices one fixed field when the channel's mux control equals the match code; otherwise it substitutes the default value. Each result is registered through a 2-entry skid buffer to the downstream field consumer. A per-channel saturating hit counter supports monitoring.

## Interface
Parameters:
- CHANNELS, 3, number of independent message channels.
- MSG_BITS, 512, message width (matches MAX_MESSAGE_BITS).
- CTRL_BITS, 4, mux-control width per channel.
- FIELD_MSB, 95, field high bit in message.
- FIELD_LSB, 64, field low bit; FW = FIELD_MSB-FIELD_LSB+1.
- MATCH_CODE, 4'h1, mux-control value that selects extraction.
- DEFAULT_VALUE, 0, FW-bit substitute on mismatch or disable.
- CNT_BITS, 16, hit counter width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- message_en  in  1  global enable, sampled at accept.
- msg_valid  in  CHANNELS  per-channel input valid.
- msg_ready  out  CHANNELS  per-channel input ready.
- message  in  CHANNELS*MSG_BITS  channel c at [c*MSG_BITS +: MSG_BITS].
- mux_control  in  CHANNELS*CTRL_BITS  per-channel message type code.
- field_valid  out  CHANNELS  output valid.
- field_ready  in  CHANNELS  downstream ready.
- field_data  out  CHANNELS*FW  extracted field or DEFAULT_VALUE.
- field_hit  out  CHANNELS  1 = field_data came from the message.
- count_clear  in  1  synchronous clear of all hit counters.
- hit_count  out  CHANNELS*CNT_BITS  saturating count of accepted hits.

## Operation
- Channels are fully independent; all per-channel behaviour below is per c.
- Accept: msg_valid & msg_ready at a rising edge.
- hit = message_en & (mux_control == MATCH_CODE), evaluated at accept.
- Payload: hit ? message[FIELD_MSB:FIELD_LSB] : DEFAULT_VALUE.
- Each accept stores one {data, hit} entry.
- Pop: field_valid & field_ready at a rising edge.
- Skid buffer states:
  - EMPTY: field_valid=0, msg_ready=1. Accept goes to ONE.
  - ONE: output register holds an entry, field_valid=1, msg_ready=1.
    - Accept without pop goes to FULL; the new entry goes to the skid register.
    - Accept with pop stays ONE; the new entry goes to the output register.
    - Pop without accept goes to EMPTY.
  - FULL: msg_ready=0.
    - Pop moves the skid entry to the output register and goes to ONE.
    - No accept is possible in FULL.
- msg_ready is a function of state only, never of field_ready. It is 0 while rst is high.
- Entries leave in acceptance order; no entry is dropped or duplicated.
- Counter:
  - +1 on each accept with hit=1.
  - Saturates at 2^CNT_BITS-1.
  - count_clear wins over a simultaneous increment; the counter goes to 0.
- message_en=0 does not block acceptance. Messages still flow, with DEFAULT_VALUE and hit=0.

## Timing
- Reset values:
  - State EMPTY; field_valid=0; field_data=DEFAULT_VALUE; field_hit=0; hit_count=0.
  - msg_ready=0 during reset and 1 the cycle after deassertion.
- Latency: an accept at edge N into EMPTY gives field_valid=1 at edge N+1 (one register stage).
- Throughput: 1 entry/cycle per channel while field_ready is held high.
- Stalls: field_data and field_hit are stable while field_valid=1 and field_ready=0.
- Reset mid-operation: all buffered entries are discarded immediately (asynchronous) and counters clear.
- hit_count updates at the accept edge and is visible the same cycle field_valid rises.

## Test plan
- Basic hit, ch0: mux_control=1, message[95:64]=32'hDEADBEEF, message_en=1, field_ready=1 -> next cycle field_valid=1, field_data=DEADBEEF, field_hit=1, hit_count[0]=1.
- Mismatch/disable, ch1:
  - mux_control=2 -> field_data=0, field_hit=0, count unchanged.
  - mux_control=1 with message_en=0 -> same result.
- Backpressure, ch2: field_ready=0, send A, B -> msg_ready falls after B.
  - C is held off.
  - Raise field_ready -> outputs A, B, C in order, no loss.
- Counter saturation and clear, CNT_BITS=2: 5 hits -> count=3.
  - count_clear together with a hit -> count=0.
- Async reset while FULL with 2 entries, rst pulsed mid-cycle -> field_valid=0 immediately, hit_count=0.
  - msg_ready=1 one cycle after release.
- Concurrency: random valid/ready on all 3 channels for 10k cycles -> each channel's output sequence equals a scoreboard of its accepts, with no cross-channel interference.
